// File: rtl/magma_decrypt.sv
// Magma (GOST R 34.12-2015) 64-bit block decryptor, one round per clock.
// Decrypts in 32 clocks after start; done pulses for one cycle with the result.
module magma_decrypt (
  input  logic         clk,
  input  logic         reset_,
  input  logic         start,
  input  logic [63:0]  data_in,
  input  logic [255:0] key,
  output logic [63:0]  data_out,
  output logic         done,
  output logic         busy
);

  typedef enum logic {StIdle, StRun} state_e;

  // pi_j tables, entry 0 in the most significant nibble
  localparam logic [63:0] PI [8] = '{
    64'hC462A5B9E8D703F1,
    64'h68239A5C1E47BD0F,
    64'hB3582FADE174C960,
    64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C,
    64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37,
    64'h17ED05834FA69CB2
  };

  state_e         r_state;
  logic [4:0]     r_round;
  logic [31:0]    r_left;
  logic [31:0]    r_right;
  logic [255:0]   r_key;
  logic [63:0]    r_data_out;
  logic           r_done;
  logic           r_busy;

  logic [2:0]     w_kidx;
  logic [31:0]    w_k;
  logic [31:0]    w_t;
  logic [31:0]    w_s;
  logic [31:0]    w_g;

  // Rounds 0..7 use K1..K8, rounds 8..31 use K8..K1
  assign w_kidx = (r_round[4:3] == 2'd0) ? r_round[2:0] : ~r_round[2:0];
  assign w_k    = r_key[(7 - int'(w_kidx)) * 32 +: 32];
  assign w_t    = r_right + w_k;

  always_comb begin
    w_s = '0;
    for (int j = 0; j < 8; j++) begin
      w_s[4*j +: 4] = PI[j][(15 - int'(w_t[4*j +: 4])) * 4 +: 4];
    end
  end

  assign w_g = {w_s[20:0], w_s[31:21]};

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state    <= StIdle;
      r_round    <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_key      <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_left  <= data_in[63:32];
            r_right <= data_in[31:0];
            r_key   <= key;
            r_round <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (r_round == 5'd31) begin
            // Last round is not swapped
            r_data_out <= {r_left ^ w_g, r_right};
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_round    <= '0;
            r_state    <= StIdle;
          end else begin
            r_left  <= r_right;
            r_right <= r_left ^ w_g;
            r_round <= r_round + 5'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule

// File: doc/magma_decrypt.md
MAGMA_DECRYPT -- requirements
Module: magma_decrypt

Interface
REQ-001 Parameters: none; block size, key size and S-box tables are fixed by GOST R 34.12-2015 (Magma).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_  input  1  reset is synchronous and active-low.
REQ-004 start  input  1  request to decrypt; sampled only while idle.
REQ-005 data_in  input  64  ciphertext block; [63:32] = left half a1, [31:0] = right half a0.
REQ-006 key  input  256  cipher key; K1 = key[255:224] ... K8 = key[31:0].
REQ-007 data_out  output  64  plaintext block; registered; held until the next completion.
REQ-008 done  output  1  one-cycle pulse when data_out is updated.
REQ-009 busy  output  1  high while rounds are in progress.

Function
REQ-010 The FSM SHALL have two states, IDLE and RUN, plus a 5-bit round counter (0..31).
REQ-011 IDLE with start=1 at edge E0: latch left<=data_in[63:32], right<=data_in[31:0], key into a 256-bit register, round<=0, state<=RUN, busy<=1.
REQ-012 IDLE with start=0: hold all registers; done<=0.
REQ-013 RUN: one round per clock; rounds execute at edges E1..E32.
REQ-014 Decryption round key for round i (0..31): i<8 -> K(i+1); i>=8 -> K(8 - (i mod 8)), i.e. K1..K8 then K8..K1 three times.
REQ-015 Round function: t = (right + Ki) mod 2^32 (carry discarded); nibble j (bits 4j+3:4j) substituted by table pi_j; result rotated left by 11 bits to give g.
REQ-016 Tables pi_0..pi_7 SHALL be the GOST R 34.12-2015 tables, indexed 0..15:
  - pi_0: C 4 6 2 A 5 B 9 E 8 D 7 0 3 F 1
  - pi_1: 6 8 2 3 9 A 5 C 1 E 4 7 B D 0 F
  - pi_2: B 3 5 8 2 F A D E 1 7 4 C 9 6 0
  - pi_3: C 8 2 1 D 4 F 6 7 0 A 5 3 E 9 B
  - pi_4: 7 F 5 A 8 1 6 D 0 9 3 E B 4 2 C
  - pi_5: 5 D F 6 9 2 C A B 7 8 1 4 3 E 0
  - pi_6: 8 E 2 5 6 9 1 C F 4 B 0 D A 3 7
  - pi_7: 1 7 E D 0 5 8 3 4 F A 6 9 C B 2
REQ-017 Each round SHALL update right<=left^g and left<=right, combinationally within that cycle; no pipelined temporaries may cause a round to use a stale value.
REQ-018 At edge E32 (round 31): data_out<={left^g, right}, done<=1, busy<=0, state<=IDLE; this is the final swap-free output.
REQ-019 Latency: done SHALL be high in the cycle following E32, i.e. exactly 32 clocks after the start edge.
REQ-020 done SHALL be high for exactly one cycle per accepted start.
REQ-021 start while busy=1 SHALL be ignored; no restart and no queuing.
REQ-022 start=1 in the cycle where done=1 SHALL be accepted, since the state is IDLE; this gives back-to-back throughput of one block per 33 cycles.
REQ-023 Changes to data_in or key after E0 SHALL NOT affect the running operation.
REQ-024 data_out SHALL change only at completion edges.

Reset
REQ-025 reset_=0 at any edge SHALL set state=IDLE, round=0, left=right=0, key register=0, data_out=0, done=0 and busy=0.
REQ-026 reset_ during RUN SHALL abort the operation with no done pulse.
REQ-027 reset_=0 SHALL take priority over start in the same cycle.

Verification
REQ-028 GOST vector: key=ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data_in=4ee901e5c2d8ca3d, start pulse -> done 32 clocks later, data_out=fedcba9876543210, busy low in the done cycle.
REQ-029 Busy-start and mid-operation key change: same vector, start re-asserted and key/data_in randomized during rounds 1..31 -> single done pulse, data_out=fedcba9876543210.
REQ-030 Back-to-back: start held high continuously with the same inputs -> done pulses every 33 cycles, each with data_out=fedcba9876543210.
REQ-031 Reset mid-operation: reset_=0 for one cycle at round 15 -> data_out=0, busy=0, no done; a following start yields the correct result 32 clocks later.
REQ-032 Round trip: 1000 random key/block pairs encrypted by the team's magma encryptor model, then decrypted by this block -> data_out equals the original plaintext on every pair.
REQ-033 Idle stability: no start for 100 cycles after reset -> done=0, busy=0, data_out=0 throughout.
